// File: rtl/otter_wb_arbiter_if.sv
// rtl/otter_wb_arbiter_if.sv - register-file write-side bus bundle for otter_wb_arbiter
//
// Purpose: groups the pipeline writeback, MDU result handshake, scoreboard
// issue/lookup and register-file write signals into one bundle.
//   slave  modport: the arbiter (consumes sources, drives rf_w_* and status)
//   master modport: the surrounding core / testbench
// Signals:
//   pipe_wb_en/addr/data   pipeline writeback
//   mdu_valid/ready/addr/data  MDU result handshake
//   issue_en/addr          long-latency issue, marks destination pending
//   rs1/rs2_addr, rs1/rs2_busy  decode scoreboard lookup
//   rf_w_en/addr/data      register file write port (registered)
//   fifo_count             MDU FIFO occupancy (registered)
interface otter_wb_arbiter_if #(
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
);
    logic             pipe_wb_en;
    logic [4:0]       pipe_wb_addr;
    logic [XLEN-1:0]  pipe_wb_data;
    logic             mdu_valid;
    logic             mdu_ready;
    logic [4:0]       mdu_addr;
    logic [XLEN-1:0]  mdu_data;
    logic             issue_en;
    logic [4:0]       issue_addr;
    logic [4:0]       rs1_addr;
    logic [4:0]       rs2_addr;
    logic             rs1_busy;
    logic             rs2_busy;
    logic             rf_w_en;
    logic [4:0]       rf_w_addr;
    logic [XLEN-1:0]  rf_w_data;
    logic [CNT_W-1:0] fifo_count;

    modport slave (
        input  pipe_wb_en, pipe_wb_addr, pipe_wb_data,
        input  mdu_valid, mdu_addr, mdu_data,
        output mdu_ready,
        input  issue_en, issue_addr,
        input  rs1_addr, rs2_addr,
        output rs1_busy, rs2_busy,
        output rf_w_en, rf_w_addr, rf_w_data,
        output fifo_count
    );

    modport master (
        output pipe_wb_en, pipe_wb_addr, pipe_wb_data,
        output mdu_valid, mdu_addr, mdu_data,
        input  mdu_ready,
        output issue_en, issue_addr,
        output rs1_addr, rs2_addr,
        input  rs1_busy, rs2_busy,
        input  rf_w_en, rf_w_addr, rf_w_data,
        input  fifo_count
    );
endinterface

// File: rtl/otter_wb_arbiter.sv
// rtl/otter_wb_arbiter.sv - register-file write arbiter: pipeline writeback vs buffered MDU results
//
// Purpose: merges in-order pipeline writeback with long-latency MDU results
// onto the single register-file write port. MDU results wait in a small FIFO;
// the pipeline always wins. A 32-bit pending scoreboard lets decode stall on
// registers whose MDU result has not yet been written.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  otter_wb_arbiter_if.slave (sources, scoreboard, rf_w_*, fifo_count)
module otter_wb_arbiter #(
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    otter_wb_arbiter_if.slave   bus
);
    localparam int               PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [4:0]      fifo_addr [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [31:0]      pending;
    logic [31:0]      pending_next;

    logic ready;
    logic push;
    logic pop;
    logic pipe_wr;

    // Ready comes only from the registered count, so a full FIFO refuses a
    // result even in a cycle where its head drains.
    assign ready   = (count < DEPTH_C);
    assign pipe_wr = bus.pipe_wb_en && (bus.pipe_wb_addr != 5'd0);
    // x0 results complete the handshake but are never stored.
    assign push    = bus.mdu_valid && ready && (bus.mdu_addr != 5'd0);
    assign pop     = !pipe_wr && (count != '0);

    assign bus.mdu_ready  = ready;
    assign bus.fifo_count = count;
    assign bus.rs1_busy   = pending[bus.rs1_addr];
    assign bus.rs2_busy   = pending[bus.rs2_addr];

    // Issue is applied after the drain clear so a same-cycle set wins.
    always_comb begin
        pending_next = pending;
        if (pop) begin
            pending_next[fifo_addr[rd_ptr]] = 1'b0;
        end
        if (bus.issue_en) begin
            pending_next[bus.issue_addr] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    // Storage carries no reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= bus.mdu_addr;
            fifo_data[wr_ptr] <= bus.mdu_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            pending <= '0;
        end else begin
            pending <= pending_next;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Write port: address/data hold when idle, only the enable drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rf_w_en   <= 1'b0;
            bus.rf_w_addr <= 5'd0;
            bus.rf_w_data <= '0;
        end else if (pipe_wr) begin
            bus.rf_w_en   <= 1'b1;
            bus.rf_w_addr <= bus.pipe_wb_addr;
            bus.rf_w_data <= bus.pipe_wb_data;
        end else if (pop) begin
            bus.rf_w_en   <= 1'b1;
            bus.rf_w_addr <= fifo_addr[rd_ptr];
            bus.rf_w_data <= fifo_data[rd_ptr];
        end else begin
            bus.rf_w_en   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_otter_wb_arbiter.sv
// tb/tb_otter_wb_arbiter.sv - self-checking bench for otter_wb_arbiter
module tb_otter_wb_arbiter;
    localparam int DEPTH = 2;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    otter_wb_arbiter_if #(.XLEN(32), .FIFO_DEPTH(DEPTH)) bus ();

    otter_wb_arbiter #(.XLEN(32), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pe;
        logic [4:0]  pa;
        logic [31:0] pd;
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic        ie;
        logic [4:0]  ia;
        logic [4:0]  r1;
        logic        x_rdy;
        logic        x_busy;
        logic        x_en;
        logic [4:0]  x_addr;
        logic [31:0] x_data;
        logic [1:0]  x_cnt;
    } vec_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    vec_t tbl[20];

    // reference model state
    ent_t        m_q[$];
    logic [31:0] m_pend;
    logic        m_en;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic pe, input logic [4:0] pa, input logic [31:0] pd,
                                input logic mv, input logic [4:0] ma, input logic [31:0] md,
                                input logic ie, input logic [4:0] ia, input logic [4:0] r1,
                                input logic x_rdy, input logic x_busy, input logic x_en,
                                input logic [4:0] x_addr, input logic [31:0] x_data,
                                input logic [1:0] x_cnt);
        vec_t v;
        v.pe = pe; v.pa = pa; v.pd = pd; v.mv = mv; v.ma = ma; v.md = md;
        v.ie = ie; v.ia = ia; v.r1 = r1; v.x_rdy = x_rdy; v.x_busy = x_busy;
        v.x_en = x_en; v.x_addr = x_addr; v.x_data = x_data; v.x_cnt = x_cnt;
        return v;
    endfunction

    task automatic drive(input logic pe, input logic [4:0] pa, input logic [31:0] pd,
                         input logic mv, input logic [4:0] ma, input logic [31:0] md,
                         input logic ie, input logic [4:0] ia,
                         input logic [4:0] r1, input logic [4:0] r2);
        bus.pipe_wb_en = pe; bus.pipe_wb_addr = pa; bus.pipe_wb_data = pd;
        bus.mdu_valid = mv; bus.mdu_addr = ma; bus.mdu_data = md;
        bus.issue_en = ie; bus.issue_addr = ia;
        bus.rs1_addr = r1; bus.rs2_addr = r2;
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pend = '0;
        m_en = 1'b0;
        m_addr = '0;
        m_data = '0;
    endtask

    // Applies one clock edge worth of the arbitration rules to the model.
    task automatic model_step();
        bit   accept;
        ent_t e;
        accept = bus.mdu_valid && (m_q.size() < DEPTH);
        if (bus.pipe_wb_en && bus.pipe_wb_addr != 0) begin
            m_en = 1'b1; m_addr = bus.pipe_wb_addr; m_data = bus.pipe_wb_data;
        end else if (m_q.size() > 0) begin
            e = m_q.pop_front();
            m_en = 1'b1; m_addr = e.addr; m_data = e.data;
            m_pend[e.addr] = 1'b0;
        end else begin
            m_en = 1'b0;
        end
        if (accept && bus.mdu_addr != 0) begin
            e.addr = bus.mdu_addr;
            e.data = bus.mdu_data;
            m_q.push_back(e);
        end
        if (bus.issue_en) m_pend[bus.issue_addr] = 1'b1;
        m_pend[0] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        //            pe pa  pd            mv ma  md            ie ia  r1   rdy bsy en addr data          cnt
        tbl[0]  = mk(1, 3, 32'hDEADBEEF, 0, 0, 0,            0, 0, 0,   1,  0,  1, 3,  32'hDEADBEEF, 0);
        tbl[1]  = mk(1, 0, 32'h11111111, 0, 0, 0,            0, 0, 0,   1,  0,  0, 3,  32'hDEADBEEF, 0);
        tbl[2]  = mk(0, 0, 0,            0, 0, 0,            1, 7, 7,   1,  0,  0, 3,  32'hDEADBEEF, 0);
        tbl[3]  = mk(0, 0, 0,            1, 7, 32'h12345678, 0, 0, 7,   1,  1,  0, 3,  32'hDEADBEEF, 1);
        tbl[4]  = mk(0, 0, 0,            0, 0, 0,            0, 0, 7,   1,  1,  1, 7,  32'h12345678, 0);
        tbl[5]  = mk(0, 0, 0,            0, 0, 0,            0, 0, 7,   1,  0,  0, 7,  32'h12345678, 0);
        tbl[6]  = mk(1, 1, 32'hA1,       1, 10, 32'h100,     0, 0, 0,   1,  0,  1, 1,  32'hA1,       1);
        tbl[7]  = mk(1, 2, 32'hA2,       1, 11, 32'h101,     0, 0, 0,   1,  0,  1, 2,  32'hA2,       2);
        tbl[8]  = mk(1, 3, 32'hA3,       1, 12, 32'h102,     0, 0, 0,   0,  0,  1, 3,  32'hA3,       2);
        tbl[9]  = mk(1, 4, 32'hA4,       1, 12, 32'h102,     0, 0, 0,   0,  0,  1, 4,  32'hA4,       2);
        tbl[10] = mk(0, 0, 0,            1, 12, 32'h102,     0, 0, 0,   0,  0,  1, 10, 32'h100,      1);
        tbl[11] = mk(0, 0, 0,            1, 12, 32'h102,     0, 0, 0,   1,  0,  1, 11, 32'h101,      1);
        tbl[12] = mk(0, 0, 0,            0, 0, 0,            0, 0, 0,   1,  0,  1, 12, 32'h102,      0);
        tbl[13] = mk(0, 0, 0,            0, 0, 0,            0, 0, 0,   1,  0,  0, 12, 32'h102,      0);
        tbl[14] = mk(0, 0, 0,            1, 9, 32'h99,       1, 9, 9,   1,  0,  0, 12, 32'h102,      1);
        tbl[15] = mk(0, 0, 0,            0, 0, 0,            1, 9, 9,   1,  1,  1, 9,  32'h99,       0);
        tbl[16] = mk(0, 0, 0,            0, 0, 0,            0, 0, 9,   1,  1,  0, 9,  32'h99,       0);
        tbl[17] = mk(0, 0, 0,            1, 0, 32'h555,      0, 0, 0,   1,  0,  0, 9,  32'h99,       0);
        tbl[18] = mk(0, 0, 0,            1, 4, 32'h44,       0, 0, 0,   1,  0,  0, 9,  32'h99,       1);
        tbl[19] = mk(1, 0, 32'h77,       0, 0, 0,            0, 0, 0,   1,  0,  1, 4,  32'h44,       0);

        rst = 1'b1;
        #1;
        chk("reset_rf_w_en", 32'(bus.rf_w_en), 0);
        chk("reset_fifo_count", 32'(bus.fifo_count), 0);
        chk("reset_mdu_ready", 32'(bus.mdu_ready), 1);
        do_reset();

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].pe, tbl[i].pa, tbl[i].pd, tbl[i].mv, tbl[i].ma, tbl[i].md,
                  tbl[i].ie, tbl[i].ia, tbl[i].r1, 0);
            #1;
            chk($sformatf("v%0d_mdu_ready", i), 32'(bus.mdu_ready), 32'(tbl[i].x_rdy));
            chk($sformatf("v%0d_rs1_busy", i), 32'(bus.rs1_busy), 32'(tbl[i].x_busy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_rf_w_en", i), 32'(bus.rf_w_en), 32'(tbl[i].x_en));
            chk($sformatf("v%0d_rf_w_addr", i), 32'(bus.rf_w_addr), 32'(tbl[i].x_addr));
            chk($sformatf("v%0d_rf_w_data", i), bus.rf_w_data, tbl[i].x_data);
            chk($sformatf("v%0d_fifo_count", i), 32'(bus.fifo_count), 32'(tbl[i].x_cnt));
        end

        // Reset mid-operation: two buffered results and pending[5] set.
        do_reset();
        drive(1, 1, 32'h1, 1, 5, 32'h55, 1, 5, 5, 0);
        @(posedge clk); #1;
        drive(1, 2, 32'h2, 1, 6, 32'h66, 0, 0, 5, 0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
        #1;
        chk("pre_rst_count", 32'(bus.fifo_count), 2);
        chk("pre_rst_busy", 32'(bus.rs1_busy), 1);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_rf_w_en", 32'(bus.rf_w_en), 0);
        chk("mid_rst_count", 32'(bus.fifo_count), 0);
        chk("mid_rst_ready", 32'(bus.mdu_ready), 1);
        chk("mid_rst_rs1_busy", 32'(bus.rs1_busy), 0);
        do_reset();

        // Randomized traffic against the queue-based model.
        for (int c = 0; c < 3000; c++) begin
            logic [4:0] pa, ma, ia;
            pa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 15));
            ma = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 15));
            ia = 5'($urandom_range(0, 15));
            drive(1'($urandom_range(0, 1)), pa, $urandom,
                  1'($urandom_range(0, 4) != 0), ma, $urandom,
                  1'($urandom_range(0, 2) == 0), ia,
                  5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
            #1;
            chk("rnd_mdu_ready", 32'(bus.mdu_ready), 32'(m_q.size() < DEPTH));
            chk("rnd_rs1_busy", 32'(bus.rs1_busy), 32'(m_pend[bus.rs1_addr]));
            chk("rnd_rs2_busy", 32'(bus.rs2_busy), 32'(m_pend[bus.rs2_addr]));
            model_step();
            @(posedge clk);
            #1;
            chk("rnd_rf_w_en", 32'(bus.rf_w_en), 32'(m_en));
            chk("rnd_rf_w_addr", 32'(bus.rf_w_addr), 32'(m_addr));
            chk("rnd_rf_w_data", bus.rf_w_data, m_data);
            chk("rnd_fifo_count", 32'(bus.fifo_count), m_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/otter_wb_arbiter.md
Name: otter_wb_arbiter

Overview:
- Write-side front end for the OTTER register file's single write port.
- Merges two result sources: in-order pipeline writeback, and a long-latency multiply/divide unit (MDU).
- MDU results are buffered in a small FIFO; the pipeline always has priority.
- Keeps a 32-entry pending scoreboard so decode can stall on registers whose MDU result has not yet been written.

Parameters:
- XLEN, 32, data width of results and of the register-file write port.
- FIFO_DEPTH, 2, number of buffered MDU results (power of two, ≥2).
- CNT_W, $clog2(FIFO_DEPTH)+1, width of fifo_count.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- pipe_wb_en  input  1  pipeline writeback valid this cycle.
- pipe_wb_addr  input  5  pipeline destination register.
- pipe_wb_data  input  XLEN  pipeline result.
- mdu_valid  input  1  MDU result offered.
- mdu_ready  output  1  FIFO can accept; high when fifo_count < FIFO_DEPTH.
- mdu_addr  input  5  MDU destination register.
- mdu_data  input  XLEN  MDU result.
- issue_en  input  1  long-latency op issued this cycle; marks its destination pending.
- issue_addr  input  5  destination of the issued op.
- rs1_addr  input  5  decode source 1.
- rs2_addr  input  5  decode source 2.
- rs1_busy  output  1  pending[rs1_addr], combinational.
- rs2_busy  output  1  pending[rs2_addr], combinational.
- rf_w_en  output  1  to register file w_en, registered.
- rf_w_addr  output  5  to register file w_addr, registered.
- rf_w_data  output  XLEN  to register file w_data, registered.
- fifo_count  output  CNT_W  current FIFO occupancy, registered.

Behaviour:
- Reset, asynchronous, takes effect immediately:
  - rf_w_en=0, rf_w_addr=0, rf_w_data=0.
  - FIFO emptied; fifo_count=0; mdu_ready=1.
  - pending bitmap all zeros; rs1_busy=rs2_busy=0.
  - In-flight MDU results are discarded.
- Enqueue: mdu_valid && mdu_ready at the clock edge pushes {mdu_addr, mdu_data}.
  - mdu_ready depends only on the registered count, never on a same-cycle drain. A full FIFO deasserts ready even in a cycle where an entry drains.
  - mdu_addr==0 completes the handshake but the entry is dropped (not enqueued, count unchanged).
- Arbitration, evaluated every edge:
  - If pipe_wb_en && pipe_wb_addr!=0: next rf_w_* = {1, pipe_wb_addr, pipe_wb_data}. The FIFO does not drain that cycle.
  - Else if FIFO non-empty: pop head; next rf_w_* = {1, head.addr, head.data}; clear pending[head.addr].
  - Else: rf_w_en=0. rf_w_addr and rf_w_data hold their previous values.
  - pipe_wb_en with addr 0 counts as no pipeline write, so the FIFO may drain that cycle.
- Latency:
  - Pipeline result appears on rf_w_* 1 cycle after it is presented.
  - MDU result, FIFO empty, no pipeline traffic: enqueued at edge N, drained at edge N+1, rf_w_en high during cycle N+1→N+2. There is no enqueue-to-output bypass.
- Simultaneous push and pop: both happen; fifo_count unchanged. Pointers wrap modulo FIFO_DEPTH.
- Scoreboard:
  - issue_en && issue_addr!=0 sets pending[issue_addr].
  - A set and a drain-clear of the same address in the same cycle: set wins.
  - pending[0] is always 0.
  - Issuing to an already-pending address is legal; the bit simply stays set.
  - Preventing WAW ordering with the pipeline is the hazard unit's job. This block writes whatever it is given, in priority order.
- Starvation: continuous pipeline writes can hold the FIFO indefinitely; the MDU sees back-pressure through mdu_ready.
- FIFO entries leave in strict FIFO order.

Test Plan:
- Reset mid-operation: FIFO holds 2 entries and pending[5]=1, assert rst → immediately rf_w_en=0, fifo_count=0, mdu_ready=1, rs1_busy=0 with rs1_addr=5.
- Pipeline only: pipe_wb_en=1, addr=3, data=0xDEADBEEF at edge N → rf_w_en=1, rf_w_addr=3, rf_w_data=0xDEADBEEF after edge N; with addr=0 instead → rf_w_en=0.
- Scoreboard round trip: issue_en addr=7 → rs1_busy=1 (rs1_addr=7). MDU delivers addr=7, data=0x12345678 with pipeline idle → rf_w_* = {1, 7, 0x12345678} two edges after the handshake; rs1_busy=0 after the drain edge.
- Priority and back-pressure: pipe_wb_en held high 4 cycles while the MDU offers 3 results → first 2 accepted, mdu_ready=0 with fifo_count=2. Only pipeline writes appear. After the pipeline idles, the FIFO drains in order and the third result is accepted when ready returns.
- Same-cycle set/clear: drain of addr 9 coincides with issue_en addr=9 → pending[9] stays 1.
- Full FIFO with simultaneous drain: count=2, pipeline idle, mdu_valid=1 → mdu_ready=0, no push; count becomes 1 and ready rises the next cycle.
